// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 hex keypad scanner.
//   - state_t      : scanner FSM states (SCAN, DEBOUNCE, HELD)
//   - key_code_t   : 4-bit key code, row*4 + col
//   - one_hot_t    : decoded row sample (valid flag + row index)
//   - one_hot_index: decode an active-low 4-bit vector; valid only when
//                    exactly one bit is low
package keypad_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } one_hot_t;

    // All-high (no key) and multi-low (ghosting) both come back invalid.
    function automatic one_hot_t one_hot_index(input logic [3:0] vec_n);
        one_hot_t res;
        res = '0;
        case (vec_n)
            4'b1110: begin res.valid = 1'b1; res.idx = 2'd0; end
            4'b1101: begin res.valid = 1'b1; res.idx = 2'd1; end
            4'b1011: begin res.valid = 1'b1; res.idx = 2'd2; end
            4'b0111: begin res.valid = 1'b1; res.idx = 2'd3; end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: key handshake and display-value bus between the scanner and
// the CPU/MMIO side.
//   key_valid/key_code : pending key, valid/ready handshake (master drives)
//   key_ready          : consumer pop (slave drives)
//   value              : 32-bit nibble shift register, newest in [3:0]
//   overflow           : sticky dropped-key flag
//   clr                : synchronous clear of value and overflow (slave drives)
interface keypad_if;
    import keypad_pkg::*;

    logic        key_valid;
    key_code_t   key_code;
    logic        key_ready;
    logic [31:0] value;
    logic        overflow;
    logic        clr;

    modport master (
        output key_valid, key_code, value, overflow,
        input  key_ready, clr
    );

    modport slave (
        input  key_valid, key_code, value, overflow,
        output key_ready, clr
    );

endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchronizer for the asynchronous keypad rows.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (two clk cycles of delay)
module keypad_sync #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex matrix keypad scanner with debounce, valid/ready
// key handshake and a 32-bit shift register of entered nibbles.
//   clk, rst : system clock, synchronous active-high reset
//   rows     : keypad rows, active-low, asynchronous
//   cols     : keypad column drive, active-low one-hot
//   kp       : keypad_if.master (key_valid/key_code/key_ready, value,
//              overflow, clr)
// Each column is driven for SCAN_DIV cycles and rows are judged on the last
// cycle of the dwell. A press or release must be seen on DEBOUNCE
// consecutive samples to count.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    keypad_if.master   kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE);

    state_t      state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]  col_q, col_d;
    logic [1:0]  row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        key_valid_q, key_valid_d;
    key_code_t   key_code_q, key_code_d;
    logic [31:0] value_q, value_d;
    logic        overflow_q, overflow_d;

    logic [3:0]  srows;
    one_hot_t    hit_s;
    logic        sample;
    logic        accept;
    key_code_t   code;
    logic [CW-1:0] cnt_inc;

    keypad_sync #(.WIDTH(4), .RST_VAL(4'b1111)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rows),
        .q   (srows)
    );

    assign hit_s   = one_hot_index(srows);
    assign sample  = (dwell_q == DWELL_LAST);
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        dwell_d = sample ? '0 : dwell_q + DW'(1);
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;

        if (sample) begin
            case (state_q)
                keypad_pkg::SCAN: begin
                    if (hit_s.valid) begin
                        row_d = hit_s.idx;
                        if (DEBOUNCE == 1) begin
                            // Single-sample debounce: accept straight away,
                            // cnt becomes the release counter.
                            accept  = 1'b1;
                            state_d = keypad_pkg::HELD;
                            cnt_d   = '0;
                        end else begin
                            state_d = keypad_pkg::DEBOUNCE;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                keypad_pkg::DEBOUNCE: begin
                    if (hit_s.valid && hit_s.idx == row_q) begin
                        if (cnt_inc == CNT_LAST) begin
                            accept  = 1'b1;
                            state_d = keypad_pkg::HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = keypad_pkg::SCAN;
                        col_d   = col_q + 2'd1;
                        cnt_d   = '0;
                    end
                end
                keypad_pkg::HELD: begin
                    // Any hit (even another row) means something is still down.
                    if (hit_s.valid) begin
                        cnt_d = '0;
                    end else if (cnt_inc == CNT_LAST) begin
                        state_d = keypad_pkg::SCAN;
                        col_d   = col_q + 2'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = keypad_pkg::SCAN;
                    cnt_d   = '0;
                end
            endcase
        end

        // row_d carries the fresh row on a direct SCAN accept.
        code = {row_d, col_q};

        value_d     = kp.clr ? '0 : value_q;
        overflow_d  = kp.clr ? 1'b0 : overflow_q;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;

        if (key_valid_q && kp.key_ready)
            key_valid_d = 1'b0;

        if (accept) begin
            value_d = {value_d[27:0], code};
            if (!key_valid_q || kp.key_ready) begin
                key_valid_d = 1'b1;
                key_code_d  = code;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= keypad_pkg::SCAN;
            dwell_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            value_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            value_q     <= value_d;
            overflow_q  <= overflow_d;
        end
    end

    assign cols        = ~(KEY_COLS'(1) << col_q);
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.value     = value_q;
    assign kp.overflow  = overflow_q;

endmodule
